pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed inter-stage latches between the EX, MEM and WB stages. Each instance carries a control-field bundle, a data bundle and a destination-register tag. It adds a valid/ready handshake, a two-entry skid buffer so back-pressure does not combinationally reach the upstream stage, and a synchronous flush that inserts bubbles. A bubble is a beat with all control bits zero, i.e. a NOP that writes neither memory nor the register file.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_entry.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } state_e;

  // NOP control bit, replicated to the control width by its users
  localparam logic CTRL_NOP = 1'b0;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry {ctrl, data, tag}; control can be cleared to a NOP
// independently so that data/tag keep their last values on drain or flush.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            clr_ctrl,
  input  logic [CTRL_W+DATA_W+TAG_W-1:0]  d,
  output logic [CTRL_W+DATA_W+TAG_W-1:0]  q
);

  localparam int PAY_W = DATA_W + TAG_W;
  localparam int W     = CTRL_W + PAY_W;

  logic [CTRL_W-1:0] ctrl_q;
  logic [PAY_W-1:0]  payload_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      payload_q <= '0;
    end else begin
      if (clr_ctrl)
        ctrl_q <= {CTRL_W{CTRL_NOP}};
      else if (load)
        ctrl_q <= d[W-1 -: CTRL_W];
      if (load)
        payload_q <= d[PAY_W-1:0];
    end
  end

  assign q = {ctrl_q, payload_q};

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with valid/ready handshake, two-entry skid
// buffer and synchronous flush that inserts NOP bubbles.
//
//   state   | meaning
//   EMPTY   | no beat held, outputs show a bubble
//   ONE     | main holds a beat, skid empty
//   FULL    | main and skid both hold beats, upstream stalled
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  localparam int W = CTRL_W + DATA_W + TAG_W;

  state_e state_q, state_d;
  logic   accept, emit;
  logic   main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic [W-1:0] in_bundle, main_d, main_q, skid_q;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign occupancy = state_q;

  // A beat offered during flush is dropped, so it never counts as accepted
  assign accept = in_valid & in_ready & ~flush;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = S_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d   = S_ONE;
            main_load = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = S_FULL;
            skid_load = 1'b1;
          end else if (emit) begin
            state_d  = S_EMPTY;
            main_clr = 1'b1;
          end
        end
        S_FULL: begin
          if (emit) begin
            state_d        = S_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = S_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign in_bundle = {in_ctrl, in_data, in_tag};
  assign main_d    = main_from_skid ? skid_q : in_bundle;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clr_ctrl (main_clr),
    .d        (main_d),
    .q        (main_q)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clr_ctrl (skid_clr),
    .d        (in_bundle),
    .q        (skid_q)
  );

  assign out_ctrl = main_q[W-1 -: CTRL_W];
  assign out_data = main_q[DATA_W+TAG_W-1 : TAG_W];
  assign out_tag  = main_q[TAG_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default widths plus a narrow instance
// driven in parallel to confirm bit-exact fields at CTRL_W=2/DATA_W=32/TAG_W=3.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [3:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  logic        in_ready2, out_valid2;
  logic [1:0]  out_ctrl2;
  logic [31:0] out_data2;
  logic [2:0]  out_tag2;
  logic [1:0]  occupancy2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.CTRL_W(2), .DATA_W(32), .TAG_W(3)) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl[1:0]), .in_data(in_data[31:0]), .in_tag(in_tag[2:0]),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2), .out_tag(out_tag2),
    .occupancy(occupancy2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [63:0] d, input logic [4:0] t);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_tag   = t;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic [4:0] t, input logic [1:0] occ);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ctrl"},  64'(out_ctrl), 64'hB);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_tag"},   64'(out_tag), 64'(t));
    chk({tag, "_occ"},   64'(occupancy), 64'(occ));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ctrl"},  64'(out_ctrl), 64'd0);
    chk({tag, "_occ"},   64'(occupancy), 64'd0);
    chk({tag, "_rdy"},   64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk_empty("rst");
    chk("rst_data", out_data, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_n_ctrl", 64'(out_ctrl2), 64'd0);
    rst = 1'b1;

    // streaming, out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1011, 64'(i), 5'(i + 1));
      @(negedge clk);
      chk_beat($sformatf("str%0d", i), 64'(i), 5'(i + 1), 2'd1);
      chk($sformatf("str%0d_rdy", i), 64'(in_ready), 64'd1);
      chk($sformatf("nar%0d_ctrl", i), 64'(out_ctrl2), 64'd3);
      chk($sformatf("nar%0d_data", i), 64'(out_data2), 64'(i));
      chk($sformatf("nar%0d_tag", i), 64'(out_tag2), 64'((i + 1) % 8));
      chk($sformatf("nar%0d_occ", i), 64'(occupancy2), 64'd1);
    end
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    @(negedge clk);
    chk_empty("drain");

    // back-pressure
    drive(1'b1, 4'b1011, 64'd10, 5'd10);
    @(negedge clk);
    chk_beat("bp10a", 64'd10, 5'd10, 2'd1);
    drive(1'b1, 4'b1011, 64'd11, 5'd11);
    out_ready = 1'b0;
    @(negedge clk);
    chk_beat("bp10b", 64'd10, 5'd10, 2'd2);
    chk("bp_rdy0", 64'(in_ready), 64'd0);
    drive(1'b1, 4'b1011, 64'd12, 5'd12);
    @(negedge clk);
    chk_beat("bp10c", 64'd10, 5'd10, 2'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("bp11", 64'd11, 5'd11, 2'd1);
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk_beat("bp12", 64'd12, 5'd12, 2'd1);
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    @(negedge clk);
    chk_empty("bp_end");

    // simultaneous accept and emit in ONE
    out_ready = 1'b0;
    drive(1'b1, 4'b1011, 64'h55, 5'd1);
    @(negedge clk);
    chk_beat("sim55", 64'h55, 5'd1, 2'd1);
    drive(1'b1, 4'b1011, 64'hAA, 5'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("simAA", 64'hAA, 5'd2, 2'd1);
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    out_ready = 1'b0;
    @(negedge clk);
    chk_beat("hold", 64'hAA, 5'd2, 2'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk_empty("sim_end");

    // flush when FULL, beat 3 offered alongside
    out_ready = 1'b0;
    drive(1'b1, 4'b1011, 64'd1, 5'd1);
    @(negedge clk);
    drive(1'b1, 4'b1011, 64'd2, 5'd2);
    @(negedge clk);
    chk_beat("fl_full", 64'd1, 5'd1, 2'd2);
    drive(1'b1, 4'b1011, 64'd3, 5'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    chk_empty("fl_full_post");
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_empty("fl_full_none");

    // flush in ONE with an acceptable beat offered: beat must be dropped
    drive(1'b1, 4'b1011, 64'd7, 5'd7);
    @(negedge clk);
    chk_beat("fl_one", 64'd7, 5'd7, 2'd1);
    drive(1'b1, 4'b1011, 64'd8, 5'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    chk_empty("fl_one_post");
    @(negedge clk);
    chk_empty("fl_one_none");

    // asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 4'b1011, 64'h21, 5'd7);
    @(negedge clk);
    drive(1'b1, 4'b1011, 64'h22, 5'd7);
    @(negedge clk);
    chk_beat("ar_full", 64'h21, 5'd7, 2'd2);
    drive(1'b0, 4'b0, 64'd0, 5'd0);
    #2 rst = 1'b0;
    #1;
    chk_empty("ar");
    chk("ar_data", out_data, 64'd0);
    chk("ar_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_empty("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
